// File: rtl/spi_pkg.sv
// Shared constants for the SPI register bank: register map, bit positions,
// writable masks and reset values.
package spi_pkg;

    localparam int unsigned REG_W = 8;

    localparam int unsigned ADDR_CR1 = 0;
    localparam int unsigned ADDR_CR2 = 1;
    localparam int unsigned ADDR_BR  = 2;
    localparam int unsigned ADDR_SR  = 3;
    localparam int unsigned ADDR_DR  = 5;

    localparam int unsigned CR1_SPIE  = 7;
    localparam int unsigned CR1_SPE   = 6;
    localparam int unsigned CR1_SPTIE = 5;
    localparam int unsigned CR1_MSTR  = 4;
    localparam int unsigned CR1_CPOL  = 3;
    localparam int unsigned CR1_CPHA  = 2;
    localparam int unsigned CR1_SSOE  = 1;
    localparam int unsigned CR1_LSBFE = 0;

    localparam int unsigned CR2_MODFEN  = 4;
    localparam int unsigned CR2_BIDIROE = 3;
    localparam int unsigned CR2_SPISWAI = 1;
    localparam int unsigned CR2_SPC0    = 0;

    localparam int unsigned SR_SPIF  = 7;
    localparam int unsigned SR_OVRF  = 6;
    localparam int unsigned SR_SPTEF = 5;
    localparam int unsigned SR_MODF  = 4;

    localparam logic [REG_W-1:0] CR2_WMASK   = 8'h1B;
    localparam logic [REG_W-1:0] BR_WMASK    = 8'h77;
    localparam logic [REG_W-1:0] CR1_RST_DEF = 8'h04;
    localparam logic [REG_W-1:0] CR2_RST     = 8'h00;
    localparam logic [REG_W-1:0] BR_RST      = 8'h00;

endpackage

// File: rtl/spi_status_flags.sv
// SPIF / MODF / OVRF flags with their read-sequence clear arming.
// SPI_OVERRUN_EN adds OVRF and drops receive data arriving while SPIF is pending.
module spi_status_flags (
    input  logic clk,
    input  logic rst,
    input  logic rx_set,
    input  logic modf_set,
    input  logic sr_rd,
    input  logic dr_rd,
    input  logic cr1_wr,
    output logic spif,
    output logic modf,
    output logic ovrf,
    output logic rx_load_c
);

    logic spif_arm;
    logic modf_arm;
    logic spif_clr;
    logic modf_clr;

    assign spif_clr = dr_rd & spif_arm;
    assign modf_clr = cr1_wr & modf_arm;

`ifdef SPI_OVERRUN_EN
    logic overrun;

    // A pending, uncleared SPIF turns a new receive into an overrun.
    assign overrun   = rx_set & spif & ~spif_clr;
    assign rx_load_c = rx_set & ~overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovrf <= 1'b0;
        end else if (overrun) begin
            ovrf <= 1'b1;
        end else if (spif_clr) begin
            ovrf <= 1'b0;
        end
    end
`else
    assign ovrf      = 1'b0;
    assign rx_load_c = rx_set;
`endif

    // Set always beats the clear sequence completing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spif     <= 1'b0;
            spif_arm <= 1'b0;
            modf     <= 1'b0;
            modf_arm <= 1'b0;
        end else begin
            if (rx_set) begin
                spif <= 1'b1;
            end else if (spif_clr) begin
                spif <= 1'b0;
            end

            if (spif_clr) begin
                spif_arm <= 1'b0;
            end else if (sr_rd && spif) begin
                spif_arm <= 1'b1;
            end

            if (modf_set) begin
                modf <= 1'b1;
            end else if (modf_clr) begin
                modf <= 1'b0;
            end

            if (modf_clr) begin
                modf_arm <= 1'b0;
            end else if (sr_rd && modf) begin
                modf_arm <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_reg_bank.sv
// CPU-facing SPI register bank: CR1/CR2/BR/SR/DR, tx/rx buffer handshake and irq.
// Optional overrun detection (SR bit 6) is enabled by defining SPI_OVERRUN_EN.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int unsigned       DATA_W  = 8,
    parameter int unsigned       ADDR_W  = 3,
    parameter logic [REG_W-1:0]  CR1_RST = CR1_RST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              spie,
    output logic              spe,
    output logic              sptie,
    output logic              mstr,
    output logic              cpol,
    output logic              cpha,
    output logic              ssoe,
    output logic              lsbfe,
    output logic              modfen,
    output logic              bidiroe,
    output logic              spiswai,
    output logic              spc0,
    output logic [2:0]        sppr,
    output logic [2:0]        spr,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              mode_fault,
    output logic              irq
);

    logic [REG_W-1:0]  cr1;
    logic [REG_W-1:0]  cr2;
    logic [REG_W-1:0]  br;
    logic              sptef;
    logic [DATA_W-1:0] rx_buf;
    logic              spif;
    logic              modf;
    logic              ovrf;
    logic              rx_load_c;

    logic              rd_act;
    logic              wr_cr1;
    logic              wr_cr2;
    logic              wr_br;
    logic              wr_dr;
    logic              rd_sr;
    logic              rd_dr;
    logic [REG_W-1:0]  sr_val;
    logic [DATA_W-1:0] rd_mux;

    // A simultaneous write suppresses the read.
    assign rd_act = rd_en & ~wr_en;
    assign wr_cr1 = wr_en  && (addr == ADDR_W'(ADDR_CR1));
    assign wr_cr2 = wr_en  && (addr == ADDR_W'(ADDR_CR2));
    assign wr_br  = wr_en  && (addr == ADDR_W'(ADDR_BR));
    assign wr_dr  = wr_en  && (addr == ADDR_W'(ADDR_DR));
    assign rd_sr  = rd_act && (addr == ADDR_W'(ADDR_SR));
    assign rd_dr  = rd_act && (addr == ADDR_W'(ADDR_DR));

    assign spie    = cr1[CR1_SPIE];
    assign spe     = cr1[CR1_SPE];
    assign sptie   = cr1[CR1_SPTIE];
    assign mstr    = cr1[CR1_MSTR];
    assign cpol    = cr1[CR1_CPOL];
    assign cpha    = cr1[CR1_CPHA];
    assign ssoe    = cr1[CR1_SSOE];
    assign lsbfe   = cr1[CR1_LSBFE];
    assign modfen  = cr2[CR2_MODFEN];
    assign bidiroe = cr2[CR2_BIDIROE];
    assign spiswai = cr2[CR2_SPISWAI];
    assign spc0    = cr2[CR2_SPC0];
    assign sppr    = br[6:4];
    assign spr     = br[2:0];

    spi_status_flags u_flags (
        .clk       (clk),
        .rst       (rst),
        .rx_set    (rx_valid),
        .modf_set  (mode_fault & mstr & modfen),
        .sr_rd     (rd_sr),
        .dr_rd     (rd_dr),
        .cr1_wr    (wr_cr1),
        .spif      (spif),
        .modf      (modf),
        .ovrf      (ovrf),
        .rx_load_c (rx_load_c)
    );

    always_comb begin
        sr_val           = '0;
        sr_val[SR_SPIF]  = spif;
        sr_val[SR_OVRF]  = ovrf;
        sr_val[SR_SPTEF] = sptef;
        sr_val[SR_MODF]  = modf;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_W'(ADDR_CR1): rd_mux = DATA_W'(cr1);
            ADDR_W'(ADDR_CR2): rd_mux = DATA_W'(cr2);
            ADDR_W'(ADDR_BR):  rd_mux = DATA_W'(br);
            ADDR_W'(ADDR_SR):  rd_mux = DATA_W'(sr_val);
            ADDR_W'(ADDR_DR):  rd_mux = rx_buf;
            default:           rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cr1      <= CR1_RST;
            cr2      <= CR2_RST;
            br       <= BR_RST;
            sptef    <= 1'b1;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            rx_buf   <= '0;
            rdata    <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_cr1) cr1 <= wdata[REG_W-1:0];
            if (wr_cr2) cr2 <= wdata[REG_W-1:0] & CR2_WMASK;
            if (wr_br)  br  <= wdata[REG_W-1:0] & BR_WMASK;

            // Disabling the SPI abandons any pending transmit word.
            if (wr_cr1 && !wdata[CR1_SPE]) begin
                tx_valid <= 1'b0;
                sptef    <= 1'b1;
            end else if (wr_dr && sptef && spe) begin
                tx_data  <= wdata;
                tx_valid <= 1'b1;
                sptef    <= 1'b0;
            end else if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
                sptef    <= 1'b1;
            end

            if (rx_load_c) rx_buf <= rx_data;
            if (rd_act)    rdata  <= rd_mux;

            irq <= (spie & (spif | modf | ovrf)) | (sptie & sptef & spe);
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomised scoreboard bench for spi_reg_bank against a register-level reference model.
// Define SPI_OVERRUN_EN for both bench and RTL to cover the overrun build.
module tb_spi_reg_bank;

    logic       clk;
    logic       rst;
    logic [2:0] addr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic spie, spe, sptie, mstr, cpol, cpha, ssoe, lsbfe;
    logic modfen, bidiroe, spiswai, spc0;
    logic [2:0] sppr;
    logic [2:0] spr;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       mode_fault;
    logic       irq;

    spi_reg_bank #(.DATA_W(8), .ADDR_W(3), .CR1_RST(8'h04)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wdata(wdata), .rdata(rdata),
        .spie(spie), .spe(spe), .sptie(sptie), .mstr(mstr), .cpol(cpol),
        .cpha(cpha), .ssoe(ssoe), .lsbfe(lsbfe),
        .modfen(modfen), .bidiroe(bidiroe), .spiswai(spiswai), .spc0(spc0),
        .sppr(sppr), .spr(spr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .mode_fault(mode_fault),
        .irq(irq)
    );

    typedef struct {
        logic [7:0] cr1, cr2, br, txd, rxbuf, rdata;
        logic spif, modf, ovrf, sptef, txv, spif_arm, modf_arm, irq;
    } model_t;

    typedef struct {
        time        t;
        logic [7:0] rdata, txd, cr1;
        logic       irq, txv;
        logic [3:0] cr2;
        logic [2:0] sppr, spr;
    } exp_t;

    model_t m;
    exp_t   exp_q[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;
    logic       g_txr = 1'b0;
    logic       g_rxv = 1'b0;
    logic       g_mf  = 1'b0;
    logic [7:0] g_rxd = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] reg_read(input logic [2:0] a);
        case (a)
            3'd0:    return m.cr1;
            3'd1:    return m.cr2;
            3'd2:    return m.br;
            3'd3:    return {m.spif, m.ovrf, m.sptef, m.modf, 4'b0000};
            3'd5:    return m.rxbuf;
            default: return 8'h00;
        endcase
    endfunction

    // One bus cycle: drive inputs, advance the reference model, queue the expected outputs.
    task automatic cycle(input logic we, input logic re, input logic [2:0] a, input logic [7:0] wd);
        model_t n;
        exp_t   e;
        logic   rd, en, clr, ovr, mclr;
        wr_en = we; rd_en = re; addr = a; wdata = wd;
        tx_ready = g_txr; rx_valid = g_rxv; rx_data = g_rxd; mode_fault = g_mf;

        n  = m;
        rd = re && !we;
        en = m.cr1[6];
        if (we) begin
            case (a)
                3'd0: n.cr1 = wd;
                3'd1: n.cr2 = wd & 8'h1B;
                3'd2: n.br  = wd & 8'h77;
                3'd5: if (m.sptef && en) begin n.txv = 1'b1; n.txd = wd; n.sptef = 1'b0; end
                default: ;
            endcase
        end
        if (m.txv && g_txr) begin n.txv = 1'b0; n.sptef = 1'b1; end
        if (we && a == 3'd0 && !wd[6]) begin n.txv = 1'b0; n.sptef = 1'b1; end
        if (rd) n.rdata = reg_read(a);

        clr = rd && a == 3'd5 && m.spif_arm;
`ifdef SPI_OVERRUN_EN
        ovr = g_rxv && m.spif && !clr;
`else
        ovr = 1'b0;
`endif
        if (g_rxv) begin
            n.spif = 1'b1;
            if (ovr) n.ovrf = 1'b1;
            else     n.rxbuf = g_rxd;
        end else if (clr) begin
            n.spif = 1'b0;
        end
        if (clr) begin n.spif_arm = 1'b0; n.ovrf = 1'b0; end
        if (rd && a == 3'd3 && m.spif) n.spif_arm = 1'b1;

        mclr = we && a == 3'd0 && m.modf_arm;
        if (g_mf && m.cr1[4] && m.cr2[4]) n.modf = 1'b1;
        else if (mclr)                    n.modf = 1'b0;
        if (mclr) n.modf_arm = 1'b0;
        if (rd && a == 3'd3 && m.modf) n.modf_arm = 1'b1;

        n.irq = (m.cr1[7] && (m.spif || m.modf || m.ovrf)) || (m.cr1[5] && m.sptef && en);
        m = n;

        e.t = $time; e.rdata = n.rdata; e.txd = n.txd; e.cr1 = n.cr1;
        e.irq = n.irq; e.txv = n.txv;
        e.cr2 = {n.cr2[4], n.cr2[3], n.cr2[1], n.cr2[0]};
        e.sppr = n.br[6:4]; e.spr = n.br[2:0];
        exp_q.push_back(e);

        @(posedge clk);
        @(negedge clk);
        g_rxv = 1'b0;
        g_mf  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d); cycle(1'b1, 1'b0, a, d); endtask
    task automatic rd(input logic [2:0] a);                       cycle(1'b0, 1'b1, a, 8'h00); endtask
    task automatic idle(input int n); for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 8'h00); endtask

    // Monitor: compare every cycle's registered outputs against the queued expectation.
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0 && exp_q[0].t < $time) begin
            mon_e = exp_q.pop_front();
            chk("rdata",    32'(rdata),    32'(mon_e.rdata));
            chk("irq",      32'(irq),      32'(mon_e.irq));
            chk("tx_valid", 32'(tx_valid), 32'(mon_e.txv));
            chk("tx_data",  32'(tx_data),  32'(mon_e.txd));
            chk("cr1_bits", 32'({spie, spe, sptie, mstr, cpol, cpha, ssoe, lsbfe}), 32'(mon_e.cr1));
            chk("cr2_bits", 32'({modfen, bidiroe, spiswai, spc0}), 32'(mon_e.cr2));
            chk("baud",     32'({sppr, spr}), 32'({mon_e.sppr, mon_e.spr}));
        end
    end

    initial begin
        rst = 1'b1; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0; mode_fault = 1'b0;
        m = '{cr1: 8'h04, cr2: 8'h00, br: 8'h00, txd: 8'h00, rxbuf: 8'h00, rdata: 8'h00,
              spif: 1'b0, modf: 1'b0, ovrf: 1'b0, sptef: 1'b1, txv: 1'b0,
              spif_arm: 1'b0, modf_arm: 1'b0, irq: 1'b0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset values
        idle(1); rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd3); rd(3'd7); idle(1);
        // Write masks and decoded outputs
        wr(3'd1, 8'hFF); wr(3'd2, 8'hFF); rd(3'd1); rd(3'd2); idle(1);
        // Transmit with delayed ready, second write ignored while busy
        g_txr = 1'b0; wr(3'd0, 8'h40); wr(3'd5, 8'hA5); idle(3); wr(3'd5, 8'h5A);
        g_txr = 1'b1; idle(2); rd(3'd3); g_txr = 1'b0;
        // Receive and SPIF clear sequence
        wr(3'd0, 8'hC0); g_rxd = 8'h3C; g_rxv = 1'b1; idle(1); idle(1);
        rd(3'd5); rd(3'd3); rd(3'd5); idle(2); rd(3'd3);
        // Mode fault set, clear, and masked by modfen=0
        wr(3'd0, 8'h50); wr(3'd1, 8'h10); g_mf = 1'b1; idle(1); rd(3'd3);
        wr(3'd0, 8'h50); rd(3'd3); wr(3'd1, 8'h00); g_mf = 1'b1; idle(1); rd(3'd3);
        // Back-to-back receives without a read (overrun path when enabled)
        g_rxd = 8'h11; g_rxv = 1'b1; idle(1); g_rxd = 8'h22; g_rxv = 1'b1; idle(1);
        rd(3'd5); rd(3'd3); rd(3'd5); rd(3'd3);
        // Clearing DR read colliding with a new receive
        g_rxd = 8'h33; g_rxv = 1'b1; idle(1); rd(3'd3); g_rxd = 8'h44; g_rxv = 1'b1; rd(3'd5); rd(3'd3); rd(3'd5);
        // Simultaneous read/write, then spe cleared with a word pending
        cycle(1'b1, 1'b1, 3'd2, 8'h35); rd(3'd2);
        wr(3'd0, 8'h60); wr(3'd5, 8'h77); idle(1); wr(3'd0, 8'h00); idle(1); rd(3'd3);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] a;
            logic [7:0] d;
            int unsigned op;
            a  = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            op = $urandom_range(0, 9);
            if (a == 3'd0 && ($urandom % 4) != 0) d[6] = 1'b1;
            g_txr = ($urandom % 3) != 0;
            g_rxv = ($urandom % 8) == 0;
            g_rxd = 8'($urandom);
            g_mf  = ($urandom % 10) == 0;
            if (op < 3)       cycle(1'b1, 1'b0, a, d);
            else if (op < 6)  cycle(1'b0, 1'b1, a, d);
            else if (op == 6) cycle(1'b1, 1'b1, a, d);
            else              cycle(1'b0, 1'b0, a, d);
        end

        g_txr = 1'b0;
        idle(1);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
